// File: rtl/dcache_wb_ctrl_if.sv
// Memory-side types for the data cache, plus the interface that bundles the
// CPU load/store handshake and the MainMemory bus into one port.
package mem_pkg;
    localparam int BLOCKSIZE      = 128;  // line width in bits (16-byte lines)
    localparam int BYTE_ADDR_BITS = 4;    // byte offset bits inside one line

    typedef struct packed {
        logic                 Valid;
        logic                 Wen;
        logic [31:0]          Addr;
        logic [BLOCKSIZE-1:0] WriteD;
    } CacheToMem_t;

    typedef struct packed {
        logic [BLOCKSIZE-1:0] ReadD;
        logic                 Ready;
    } MemToCache_t;
endpackage

interface dcache_wb_ctrl_if;
    import mem_pkg::*;

    logic        cpu_valid_i;
    logic        cpu_wen_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_wdata_i;
    logic [3:0]  cpu_be_i;
    logic [31:0] cpu_rdata_o;
    logic        cpu_ready_o;
    CacheToMem_t Mem_o;
    MemToCache_t Mem_i;

    // The cache itself: consumes CPU requests and memory responses.
    modport slave (
        input  cpu_valid_i, cpu_wen_i, cpu_addr_i, cpu_wdata_i, cpu_be_i, Mem_i,
        output cpu_rdata_o, cpu_ready_o, Mem_o
    );

    // The environment: CPU load/store unit together with MainMemory.
    modport master (
        output cpu_valid_i, cpu_wen_i, cpu_addr_i, cpu_wdata_i, cpu_be_i, Mem_i,
        input  cpu_rdata_o, cpu_ready_o, Mem_o
    );
endinterface

// File: rtl/dcache_wb_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Hits answer one cycle after acceptance; misses write back a dirty victim
// line (if any), refill the requested line and then re-look it up in IDLE.
module dcache_wb_ctrl
    import mem_pkg::*;
#(
    parameter int SETS   = 64,
    parameter int ADDR_W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    dcache_wb_ctrl_if.slave bus
);
    localparam int IDX_BITS = $clog2(SETS);
    localparam int TAG_W    = ADDR_W - IDX_BITS - BYTE_ADDR_BITS;
    localparam int WSEL_W   = BYTE_ADDR_BITS - 2;

    typedef enum logic [2:0] {IDLE, RESP, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT} state_t;

    state_t               state_q, state_d;
    logic [TAG_W-1:0]     tag_q  [SETS];
    logic [BLOCKSIZE-1:0] data_q [SETS];
    logic [SETS-1:0]      valid_q, dirty_q;
    logic [31:0]          rdata_q;
    logic [IDX_BITS-1:0]  req_idx_q;
    logic [TAG_W-1:0]     req_tag_q;

    logic [IDX_BITS-1:0]  cur_idx;
    logic [TAG_W-1:0]     cur_tag;
    logic [WSEL_W-1:0]    cur_wsel;
    logic                 hit, lookup, wb_done, fill_done, ready_d;
    logic [ADDR_W-1:0]    victim_addr, fill_addr;
    CacheToMem_t          mem_o;
    logic [1:0]           unused_addr_bits;

    assign cur_idx          = bus.cpu_addr_i[BYTE_ADDR_BITS +: IDX_BITS];
    assign cur_tag          = bus.cpu_addr_i[ADDR_W-1 -: TAG_W];
    assign cur_wsel         = bus.cpu_addr_i[BYTE_ADDR_BITS-1:2];
    assign unused_addr_bits = bus.cpu_addr_i[1:0];

    assign hit       = valid_q[cur_idx] && (tag_q[cur_idx] == cur_tag);
    assign lookup    = (state_q == IDLE) && bus.cpu_valid_i;
    assign wb_done   = (state_q == WB_WAIT) && bus.Mem_i.Ready;
    assign fill_done = (state_q == FILL_WAIT) && bus.Mem_i.Ready;

    // The miss address is latched, so the miss completes even if the CPU drops its request.
    assign victim_addr = {tag_q[req_idx_q], req_idx_q, {BYTE_ADDR_BITS{1'b0}}};
    assign fill_addr   = {req_tag_q, req_idx_q, {BYTE_ADDR_BITS{1'b0}}};

    function automatic logic [BLOCKSIZE-1:0] merge_store(
        input logic [BLOCKSIZE-1:0] line,
        input logic [WSEL_W-1:0]    wsel,
        input logic [31:0]          wdata,
        input logic [3:0]           be
    );
        logic [BLOCKSIZE-1:0] res;
        logic [31:0]          word;
        res  = line;
        word = line[{wsel, 5'b0} +: 32];
        for (int b = 0; b < 4; b++) begin
            if (be[b]) word[8*b +: 8] = wdata[8*b +: 8];
        end
        res[{wsel, 5'b0} +: 32] = word;
        return res;
    endfunction

    // State register; reset abandons any miss in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic and the single-cycle memory request / CPU completion strobes.
    always_comb begin
        state_d = state_q;
        ready_d = 1'b0;
        mem_o   = '0;
        case (state_q)
            IDLE: begin
                if (bus.cpu_valid_i) begin
                    if (hit)                                    state_d = RESP;
                    else if (valid_q[cur_idx] && dirty_q[cur_idx]) state_d = WB_REQ;
                    else                                        state_d = FILL_REQ;
                end
            end
            RESP: begin
                ready_d = 1'b1;
                state_d = IDLE;
            end
            WB_REQ: begin
                mem_o.Valid  = 1'b1;
                mem_o.Wen    = 1'b1;
                mem_o.Addr   = victim_addr;
                mem_o.WriteD = data_q[req_idx_q];
                state_d      = WB_WAIT;
            end
            WB_WAIT: begin
                if (bus.Mem_i.Ready) state_d = FILL_REQ;
            end
            FILL_REQ: begin
                mem_o.Valid = 1'b1;
                mem_o.Addr  = fill_addr;
                state_d     = FILL_WAIT;
            end
            FILL_WAIT: begin
                if (bus.Mem_i.Ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Line status bits and the load result register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= '0;
            dirty_q <= '0;
            rdata_q <= '0;
        end else begin
            if (lookup && hit && !bus.cpu_wen_i) rdata_q <= data_q[cur_idx][{cur_wsel, 5'b0} +: 32];
            if (lookup && hit && bus.cpu_wen_i)  dirty_q[cur_idx] <= 1'b1;
            if (wb_done)                         dirty_q[req_idx_q] <= 1'b0;
            if (fill_done) begin
                valid_q[req_idx_q] <= 1'b1;
                dirty_q[req_idx_q] <= 1'b0;
            end
        end
    end

    // Tag/data arrays are never cleared; writes are suppressed under reset so a late fill is dropped.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            if (lookup && !hit) begin
                req_idx_q <= cur_idx;
                req_tag_q <= cur_tag;
            end
            if (lookup && hit && bus.cpu_wen_i)
                data_q[cur_idx] <= merge_store(data_q[cur_idx], cur_wsel, bus.cpu_wdata_i, bus.cpu_be_i);
            if (fill_done) begin
                data_q[req_idx_q] <= bus.Mem_i.ReadD;
                tag_q[req_idx_q]  <= req_tag_q;
            end
        end
    end

    assign bus.cpu_ready_o = ready_d;
    assign bus.cpu_rdata_o = rdata_q;
    assign bus.Mem_o       = mem_o;
endmodule

// File: tb/tb_dcache_wb_ctrl.sv
// Bench for dcache_wb_ctrl: directed loads/stores against a flat memory-image
// model of what every load must return, a per-set residency model that
// predicts misses, writebacks and completion latency, and a MainMemory
// responder with adjustable latency.
module tb_dcache_wb_ctrl;
    import mem_pkg::*;

    typedef struct {
        logic         wen;
        logic [31:0]  addr;
        logic [127:0] data;
    } memop_t;

    logic clk_i = 1'b0;
    logic rst_ni;
    always #5 clk_i = ~clk_i;

    dcache_wb_ctrl_if bus();

    dcache_wb_ctrl #(.SETS(64), .ADDR_W(32)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus.slave)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // Reference state
    logic [31:0]  img [logic [31:0]];       // word address -> current architectural value
    logic [127:0] mem_line [logic [31:0]];  // MainMemory contents by line address
    bit           set_valid [64];
    bit           set_dirty [64];
    logic [21:0]  set_tag [64];
    memop_t       exp_q [$];
    int           mem_lat = 1;

    // Handshake between driver and compare process
    bit           pending = 0;
    bit           exp_load;
    logic [31:0]  exp_rdata;
    int           exp_lat;
    int           cnt;
    int           last_lat;
    logic [31:0]  last_rdata;
    bit           just_done = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] pattern(input logic [31:0] a);
        return a ^ 32'h5A5A5A5A;
    endfunction

    function automatic logic [31:0] img_word(input logic [31:0] a);
        if (img.exists(a)) return img[a];
        return pattern(a);
    endfunction

    function automatic logic [127:0] img_line(input logic [31:0] la);
        return {img_word(la + 32'd12), img_word(la + 32'd8), img_word(la + 32'd4), img_word(la)};
    endfunction

    function automatic logic [127:0] mem_read(input logic [31:0] la);
        if (mem_line.exists(la)) return mem_line[la];
        return {pattern(la + 32'd12), pattern(la + 32'd8), pattern(la + 32'd4), pattern(la)};
    endfunction

    // Predict the memory traffic, latency and load value of one access, then update the model.
    task automatic model_issue(input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                               input logic [3:0] be, input bit b2b);
        int          idx;
        int          lat;
        logic [21:0] tag;
        logic [31:0] wa, old;
        memop_t      op;
        idx = int'(addr[9:4]);
        tag = addr[31:10];
        if (set_valid[idx] && set_tag[idx] == tag) begin
            lat = 1;
        end else begin
            lat = 3 + mem_lat;
            if (set_valid[idx] && set_dirty[idx]) begin
                op.wen  = 1'b1;
                op.addr = {set_tag[idx], addr[9:4], 4'h0};
                op.data = img_line(op.addr);
                exp_q.push_back(op);
                lat = 4 + 2 * mem_lat;
            end
            op.wen  = 1'b0;
            op.addr = {addr[31:4], 4'h0};
            op.data = '0;
            exp_q.push_back(op);
            set_valid[idx] = 1'b1;
            set_tag[idx]   = tag;
            set_dirty[idx] = 1'b0;
        end
        wa = {addr[31:2], 2'b00};
        if (wen) begin
            old = img_word(wa);
            for (int b = 0; b < 4; b++) if (be[b]) old[8*b +: 8] = wd[8*b +: 8];
            img[wa] = old;
            set_dirty[idx] = 1'b1;
        end
        exp_load  = !wen;
        exp_rdata = img_word(wa);
        exp_lat   = lat + (b2b ? 1 : 0);
        cnt       = 0;
        pending   = 1'b1;
    endtask

    task automatic access(input logic wen, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
        bit seen;
        bit b2b;
        b2b = just_done;
        if (!just_done) @(negedge clk_i);
        bus.cpu_valid_i = 1'b1;
        bus.cpu_wen_i   = wen;
        bus.cpu_addr_i  = addr;
        bus.cpu_wdata_i = wd;
        bus.cpu_be_i    = be;
        model_issue(wen, addr, wd, be, b2b);
        seen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk_i);
            if (bus.cpu_ready_o === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_vec++;
            n_miss++;
            $display("FAIL timeout: no cpu_ready_o for addr %h within 60 cycles", addr);
            pending = 1'b0;
        end
        just_done = 1'b1;
    endtask

    task automatic idle(input int n);
        bus.cpu_valid_i = 1'b0;
        repeat (n) @(negedge clk_i);
        just_done = 1'b0;
    endtask

    // MainMemory: samples a request mid-cycle, answers Ready mem_lat cycles later.
    initial begin
        bit           busy;
        int           left;
        logic [127:0] rd;
        busy = 1'b0;
        left = 0;
        rd   = '0;
        bus.Mem_i = '0;
        forever begin
            @(negedge clk_i);
            if (bus.Mem_o.Valid === 1'b1) begin
                if (bus.Mem_o.Wen) mem_line[bus.Mem_o.Addr] = bus.Mem_o.WriteD;
                else               rd = mem_read(bus.Mem_o.Addr);
                busy = 1'b1;
                left = mem_lat;
            end
            @(posedge clk_i);
            #1;
            bus.Mem_i.Ready = 1'b0;
            if (busy) begin
                left--;
                if (left == 0) begin
                    bus.Mem_i.Ready = 1'b1;
                    bus.Mem_i.ReadD = rd;
                    busy = 1'b0;
                end
            end
        end
    end

    // Compare process: every cycle, completion strobe and memory traffic against the model.
    initial begin
        bit rdy, mv, prev_rdy, prev_mv;
        memop_t op;
        prev_rdy = 1'b0;
        prev_mv  = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            if (pending) cnt++;
            rdy = (bus.cpu_ready_o === 1'b1);
            if (rdy) begin
                chk("ready_single_cycle", 128'(prev_rdy), 128'(0));
                if (!pending) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL spurious_ready: cpu_ready_o=1 required 0 (no request pending)");
                end else begin
                    chk("latency", 128'(cnt), 128'(exp_lat));
                    last_lat   = cnt;
                    last_rdata = bus.cpu_rdata_o;
                    if (exp_load) chk("load_data", 128'(bus.cpu_rdata_o), 128'(exp_rdata));
                    pending = 1'b0;
                end
            end
            prev_rdy = rdy;
            mv = (bus.Mem_o.Valid === 1'b1);
            if (mv) begin
                chk("mem_valid_single_cycle", 128'(prev_mv), 128'(0));
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_mem_access: addr %h wen %b, required no access",
                             bus.Mem_o.Addr, bus.Mem_o.Wen);
                end else begin
                    op = exp_q.pop_front();
                    chk("mem_wen", 128'(bus.Mem_o.Wen), 128'(op.wen));
                    chk("mem_addr", 128'(bus.Mem_o.Addr), 128'(op.addr));
                    if (op.wen) chk("mem_wdata", bus.Mem_o.WriteD, op.data);
                end
            end
            prev_mv = mv;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed stimulus
    initial begin
        rst_ni          = 1'b0;
        bus.cpu_valid_i = 1'b0;
        bus.cpu_wen_i   = 1'b0;
        bus.cpu_addr_i  = '0;
        bus.cpu_wdata_i = '0;
        bus.cpu_be_i    = '0;
        repeat (3) @(negedge clk_i);
        chk("reset_ready", 128'(bus.cpu_ready_o), 128'(0));
        chk("reset_rdata", 128'(bus.cpu_rdata_o), 128'(0));
        chk("reset_mem_valid", 128'(bus.Mem_o.Valid), 128'(0));
        chk("reset_mem_wen", 128'(bus.Mem_o.Wen), 128'(0));
        rst_ni = 1'b1;
        idle(1);

        // Cold load: clean miss, ready at cycle 4
        access(1'b0, 32'h0001_0000, 32'h0, 4'h0);
        chk("s1_rdata_lit", 128'(last_rdata), 128'(32'h5A5B_5A5A));
        chk("s1_latency_lit", 128'(last_lat), 128'(4));
        idle(2);

        // Partial store hit, then load of the merged word back-to-back
        access(1'b1, 32'h0001_0004, 32'hDEAD_BEEF, 4'b0011);
        access(1'b0, 32'h0001_0004, 32'h0, 4'h0);
        chk("s2_rdata_lit", 128'(last_rdata), 128'(32'h5A5B_BEEF));
        chk("s2_latency_lit", 128'(last_lat), 128'(2));
        idle(2);

        // Conflicting load at idx 0 evicts the dirty line
        access(1'b0, 32'h0002_0000, 32'h0, 4'h0);
        chk("s3_rdata_lit", 128'(last_rdata), 128'(32'h5A58_5A5A));
        chk("s3_latency_lit", 128'(last_lat), 128'(6));
        chk("s3_wb_word_lit", 128'(mem_read(32'h0001_0000) >> 32) & 128'hFFFF_FFFF, 128'(32'h5A5B_BEEF));
        idle(2);

        // Reload of the evicted data comes back from memory
        access(1'b0, 32'h0001_0004, 32'h0, 4'h0);
        chk("s4_rdata_lit", 128'(last_rdata), 128'(32'h5A5B_BEEF));
        chk("s4_latency_lit", 128'(last_lat), 128'(4));
        idle(2);

        // Reset while waiting for a slow fill
        mem_lat = 4;
        @(negedge clk_i);
        bus.cpu_valid_i = 1'b1;
        bus.cpu_wen_i   = 1'b0;
        bus.cpu_addr_i  = 32'h0004_0040;
        model_issue(1'b0, 32'h0004_0040, 32'h0, 4'h0, 1'b0);
        repeat (3) @(negedge clk_i);
        rst_ni          = 1'b0;
        bus.cpu_valid_i = 1'b0;
        pending         = 1'b0;
        for (int i = 0; i < 64; i++) begin
            set_valid[i] = 1'b0;
            set_dirty[i] = 1'b0;
        end
        @(negedge clk_i);
        chk("s5_ready_after_reset", 128'(bus.cpu_ready_o), 128'(0));
        chk("s5_mem_valid_after_reset", 128'(bus.Mem_o.Valid), 128'(0));
        chk("s5_rdata_after_reset", 128'(bus.cpu_rdata_o), 128'(0));
        rst_ni = 1'b1;
        repeat (4) @(negedge clk_i);
        mem_lat = 1;
        just_done = 1'b0;
        access(1'b0, 32'h0004_0040, 32'h0, 4'h0);
        chk("s5_refetch_latency_lit", 128'(last_lat), 128'(4));
        chk("s5_refetch_rdata_lit", 128'(last_rdata), 128'(32'h5A5E_5A1A));
        idle(2);

        // Back-to-back hits after one fill
        access(1'b0, 32'h0001_0000, 32'h0, 4'h0);
        access(1'b0, 32'h0001_0004, 32'h0, 4'h0);
        access(1'b1, 32'h0001_0008, 32'h1234_5678, 4'b1111);
        access(1'b0, 32'h0001_0008, 32'h0, 4'h0);
        access(1'b0, 32'h0001_000C, 32'h0, 4'h0);
        chk("s6_rdata_lit", 128'(last_rdata), 128'(32'h5A5B_5A56));
        chk("s6_latency_lit", 128'(last_lat), 128'(2));
        idle(2);

        // Store miss allocates, then the merged word reads back
        access(1'b1, 32'h0003_0010, 32'hA5A5_0F0F, 4'b1100);
        access(1'b0, 32'h0003_0010, 32'h0, 4'h0);
        chk("s7_rdata_lit", 128'(last_rdata), 128'(32'hA5A5_5A4A));
        idle(1);

        // Instruction-window address is cached like any other
        access(1'b0, 32'hBFC0_0020, 32'h0, 4'h0);
        chk("s8_rdata_lit", 128'(last_rdata), 128'(32'hE59A_5A7A));
        idle(1);

        // Dirty evictions at idx 0 and idx 1, then data recovered from memory
        access(1'b0, 32'h0005_0000, 32'h0, 4'h0);
        access(1'b0, 32'h0001_0008, 32'h0, 4'h0);
        chk("s9_rdata_lit", 128'(last_rdata), 128'(32'h1234_5678));
        access(1'b0, 32'h0007_0010, 32'h0, 4'h0);
        access(1'b0, 32'h0003_0010, 32'h0, 4'h0);
        idle(4);

        chk("mem_queue_drained", 128'(exp_q.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
